// File: rtl/register_file_param.sv
// Parameterised register file: two combinational read ports, one write port,
// per-register written flags and a saturating write counter. Define
// REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file_param #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter logic [63:0] RESET_BASE = 64'd2,
  parameter logic [63:0] RESET_STEP = 64'd2,
  parameter bit          ZERO_REG   = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       read_register1,
  input  logic [ADDR_W-1:0]       read_register2,
  input  logic                    write_enable,
  input  logic [ADDR_W-1:0]       write_register,
  input  logic [WIDTH-1:0]        write_data,
  output logic [WIDTH-1:0]        read_data1,
  output logic [WIDTH-1:0]        read_data2,
  output logic [(2**ADDR_W)-1:0]  written_mask,
  output logic [15:0]             write_count
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             write_accept;

  // Reset value wraps modulo 2**64 and is then truncated to the word width.
  function automatic logic [WIDTH-1:0] reset_value(input int unsigned idx);
    logic [63:0] v;
    v = RESET_BASE + 64'(idx) * RESET_STEP;
    return v[WIDTH-1:0];
  endfunction

  // Writes to a hardwired-zero register 0 are dropped entirely.
  always_comb begin
    write_accept = write_enable && !reset;
    if (ZERO_REG && (write_register == '0)) write_accept = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= reset_value(i);
    end else if (write_accept) begin
      regs[write_register] <= write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      written_mask <= '0;
      write_count  <= '0;
    end else if (write_accept) begin
      written_mask[write_register] <= 1'b1;
      if (write_count != COUNT_MAX) write_count <= write_count + 16'd1;
    end
  end

  always_comb begin
    read_data1 = regs[read_register1];
`ifdef REGFILE_BYPASS_EN
    if (write_accept && (read_register1 == write_register)) read_data1 = write_data;
`endif
    if (ZERO_REG && (read_register1 == '0)) read_data1 = '0;
  end

  always_comb begin
    read_data2 = regs[read_register2];
`ifdef REGFILE_BYPASS_EN
    if (write_accept && (read_register2 == write_register)) read_data2 = write_data;
`endif
    if (ZERO_REG && (read_register2 == '0)) read_data2 = '0;
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: a default instance and a ZERO_REG
// instance share one stimulus stream; expected values are hand-computed.
module tb_register_file_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] read_register1, read_register2, write_register;
  logic       write_enable;
  logic [7:0] write_data;
  logic [7:0] rd1, rd2, zrd1, zrd2;
  logic [3:0] mask, zmask;
  logic [15:0] count, zcount;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clock = ~clock;

  register_file_param dut (
    .clock(clock), .reset(reset),
    .read_register1(read_register1), .read_register2(read_register2),
    .write_enable(write_enable), .write_register(write_register),
    .write_data(write_data),
    .read_data1(rd1), .read_data2(rd2),
    .written_mask(mask), .write_count(count)
  );

  register_file_param #(.ZERO_REG(1'b1)) dut_zero (
    .clock(clock), .reset(reset),
    .read_register1(read_register1), .read_register2(read_register2),
    .write_enable(write_enable), .write_register(write_register),
    .write_data(write_data),
    .read_data1(zrd1), .read_data2(zrd2),
    .written_mask(zmask), .write_count(zcount)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Advance past the next rising edge; outputs settle before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; write_register = 2'd0; write_data = 8'h00;
    read_register1 = 2'd0; read_register2 = 2'd1;
    tick();
    reset = 1'b0;
    #1;
    check("reset_r0", rd1, 8'h02);
    check("reset_r1", rd2, 8'h04);
    check("zero_reset_r0", zrd1, 8'h00);
    check("zero_reset_r1", zrd2, 8'h04);
    read_register1 = 2'd2; read_register2 = 2'd3;
    #1;
    check("reset_r2", rd1, 8'h06);
    check("reset_r3", rd2, 8'h08);
    check("reset_mask", mask, 4'b0000);
    check("reset_count", count, 16'd0);

    // Write A5 to reg 3, read on both ports next cycle.
    write_enable = 1'b1; write_register = 2'd3; write_data = 8'hA5;
    tick();
    write_enable = 1'b0; read_register1 = 2'd3; read_register2 = 2'd3;
    #1;
    check("wr3_port1", rd1, 8'hA5);
    check("wr3_port2", rd2, 8'hA5);
    check("wr3_mask", mask, 4'b1000);
    check("wr3_count", count, 16'd1);
    check("zero_wr3_count", zcount, 16'd1);

    // Reset wins over a simultaneous write.
    reset = 1'b1; write_enable = 1'b1; write_register = 2'd1; write_data = 8'hFF;
    tick();
    reset = 1'b0; write_enable = 1'b0; read_register1 = 2'd1;
    #1;
    check("rstwr_r1", rd1, 8'h04);
    check("rstwr_r3", rd2, 8'h08);
    check("rstwr_count", count, 16'd0);
    check("rstwr_mask", mask, 4'b0000);

    // Same-cycle write/read of reg 2.
    write_enable = 1'b1; write_register = 2'd2; write_data = 8'h3C;
    read_register1 = 2'd2; read_register2 = 2'd2;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("samecyc_r2", rd1, 8'h3C);
`else
    check("samecyc_r2", rd1, 8'h06);
`endif
    tick();
    write_enable = 1'b0;
    #1;
    check("nextcyc_r2", rd1, 8'h3C);
    check("nextcyc_mask", mask, 4'b0100);

    // Write 77 to reg 0: stored normally, discarded by the zero-register instance.
    write_enable = 1'b1; write_register = 2'd0; write_data = 8'h77;
    read_register1 = 2'd0; read_register2 = 2'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr0_samecyc", rd1, 8'h77);
`else
    check("wr0_samecyc", rd1, 8'h02);
`endif
    check("zero_wr0_samecyc", zrd1, 8'h00);
    tick();
    write_enable = 1'b0;
    #1;
    check("wr0_read", rd1, 8'h77);
    check("zero_wr0_read", zrd2, 8'h00);
    check("zero_wr0_mask", zmask, 4'b0100);
    check("zero_wr0_count", zcount, 16'd1);
    check("wr0_mask", mask, 4'b0101);
    check("wr0_count", count, 16'd2);

    // Reset mid-sequence drops that cycle's write and earlier writes.
    write_enable = 1'b1; write_register = 2'd1; write_data = 8'h11;
    tick();
    reset = 1'b1; write_register = 2'd2; write_data = 8'h22;
    tick();
    reset = 1'b0; write_enable = 1'b0;
    read_register1 = 2'd1; read_register2 = 2'd2;
    #1;
    check("midrst_r1", rd1, 8'h04);
    check("midrst_r2", rd2, 8'h06);
    check("midrst_count", count, 16'd0);

    // Saturation of the write counter.
    write_enable = 1'b1; write_register = 2'd3;
    for (int i = 0; i < 65534; i++) begin
      write_data = 8'(i);
      tick();
    end
    check("count_fffe", count, 16'hFFFE);
    for (int i = 0; i < 6; i++) begin
      write_data = 8'(i + 8'h50);
      tick();
    end
    write_enable = 1'b0; read_register1 = 2'd3;
    #1;
    check("count_sat", count, 16'hFFFF);
    check("zero_count_sat", zcount, 16'hFFFF);
    check("sat_last_data", rd1, 8'h55);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
